mem_port_arbiter: RTL and testbench

//  Shares the single-port cached SDRAM controller (rd_en/wr_en/addr/data/mask/busy) between the

---
 rtl/mem_port_arbiter_pkg.sv | 37 +++
 rtl/mem_port_arbiter_rr_arb2.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and constants for the I/D memory port arbiter:
//               FSM state encoding, transaction owner codes and the
//               watchdog counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Transaction FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Which CPU port owns the in-flight transaction
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Instruction fetches always access the full word
    localparam logic [3:0] MASK_FULL = 4'hF;

    // Smallest watchdog counter, so small TIMEOUT values still count long stalls
    localparam int WDOG_MIN_W = 13;

    // Counter width able to hold TIMEOUT, never below the minimum width
    function automatic int wdog_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w > WDOG_MIN_W) ? w : WDOG_MIN_W;
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input arbiter between the instruction-fetch and data
//               requesters. Combinational grant; a registered pointer gives
//               the tie to the port not served last (round-robin), or D
//               always wins a tie when FIXED_PRIO is non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rst_x,
    input  logic i_req_ifetch,
    input  logic i_req_data,
    input  logic i_update,
    output logic o_gnt_ifetch,
    output logic o_gnt_data
);

    logic r_prio_d;   // 1: D wins the next tie, 0: I wins it
    logic w_pick_d;

    // Tie-break selection: fixed priority overrides the round-robin pointer
    assign w_pick_d     = (FIXED_PRIO != 0) ? 1'b1 : r_prio_d;
    assign o_gnt_data   = i_req_data & (~i_req_ifetch | w_pick_d);
    assign o_gnt_ifetch = i_req_ifetch & ~o_gnt_data;

    // Pointer moves to favour the port not just served, only when a grant is taken
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_prio_d <= 1'b1;
        end else if (i_update) begin
            r_prio_d <= o_gnt_ifetch;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single-port SDRAM/cache controller between the
//               Hazard3 instruction-fetch (read-only) and data (read/write)
//               ports. One transaction at a time: IDLE -> ISSUE -> WAIT ->
//               RESP. Address/data/mask are latched at grant and held for the
//               whole access; a watchdog flags over-long controller stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rst_x,
    // Instruction-fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    // Data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_mask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    // Controller port
    output logic              m_rd_en,
    output logic              m_wr_en,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_mask,
    input  logic [31:0]       m_rdata,
    input  logic              m_busy,
    // Status
    output logic              o_timeout
);

    localparam int c_cnt_w = wdog_cnt_width(TIMEOUT);

    arb_state_t        r_state;
    logic              r_wait_first;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_mask;
    logic              r_rd_en;
    logic              r_wr_en;
    logic              r_i_rvalid;
    logic              r_d_rvalid;
    logic [31:0]       r_i_rdata;
    logic [31:0]       r_d_rdata;

    logic              w_arb_open;
    logic              w_gnt_i;
    logic              w_gnt_d;
    logic              w_accept;
    logic              w_is_wr;

    // Arbitration is only offered while idle and the controller can take work
    assign w_arb_open = (r_state == IDLE) & ~m_busy;
    assign w_accept   = w_gnt_i | w_gnt_d;
    assign w_is_wr    = w_gnt_d & d_we;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arb2 (
        .clk          (clk),
        .rst_x        (rst_x),
        .i_req_ifetch (i_req & w_arb_open),
        .i_req_data   (d_req & w_arb_open),
        .i_update     (w_accept),
        .o_gnt_ifetch (w_gnt_i),
        .o_gnt_data   (w_gnt_d)
    );

    // Transaction FSM: latch the winner, strobe once, wait for the controller, respond
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_state      <= IDLE;
            r_wait_first <= 1'b0;
            r_owner      <= OWNER_I;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mask       <= '0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_i_rvalid   <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_gnt_d ? OWNER_D : OWNER_I;
                        r_we    <= w_is_wr;
                        r_addr  <= w_gnt_d ? d_addr : i_addr;
                        r_wdata <= w_gnt_d ? d_wdata : 32'h0;
                        r_mask  <= w_gnt_d ? d_mask : MASK_FULL;
                        r_rd_en <= ~w_is_wr;
                        r_wr_en <= w_is_wr;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Controller may not assert busy until the cycle after the strobe
                    r_wait_first <= 1'b1;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (!m_busy) begin
                        if (r_owner == OWNER_D) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= r_we ? 32'h0 : m_rdata;
                        end else begin
                            r_i_rvalid <= 1'b1;
                            r_i_rdata  <= m_rdata;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign i_gnt    = w_gnt_i;
    assign d_gnt    = w_gnt_d;
    assign i_rvalid = r_i_rvalid;
    assign i_rdata  = r_i_rdata;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;
    assign m_rd_en  = r_rd_en;
    assign m_wr_en  = r_wr_en;
    assign m_addr   = r_addr;
    assign m_wdata  = r_wdata;
    assign m_mask   = r_mask;

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);
            localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

            logic [c_cnt_w-1:0] r_cnt;
            logic [c_cnt_w-1:0] w_cnt_inc;
            logic               r_timeout;

            // Saturating increment so a very long stall cannot wrap the counter
            assign w_cnt_inc = (&r_cnt) ? r_cnt : (r_cnt + c_one);

            // Count WAIT cycles of the current access; flag sticks until reset
            always_ff @(posedge clk or negedge rst_x) begin
                if (!rst_x) begin
                    r_cnt     <= '0;
                    r_timeout <= 1'b0;
                end else if (r_state == ISSUE) begin
                    r_cnt <= '0;
                end else if (r_state == WAIT) begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc == c_timeout) begin
                        r_timeout <= 1'b1;
                    end
                end
            end

            assign o_timeout = r_timeout;
        end else begin : g_no_wdog
            assign o_timeout = 1'b0;
        end
    endgenerate

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               small controller model (hit = no busy, miss = busy N cycles
//               after the strobe). A second instance runs fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_x;
    always #5 clk = ~clk;

    // Shared requester stimulus
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mask;

    // Round-robin instance (TIMEOUT = 16)
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic        m_rd_en, m_wr_en, m_busy, o_timeout;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_mask;

    // Fixed-priority instance, always-hit controller
    logic        f_i_gnt, f_i_rvalid, f_d_gnt, f_d_rvalid;
    logic [31:0] f_i_rdata, f_d_rdata;
    logic        f_m_rd_en, f_m_wr_en, f_m_busy, f_o_timeout;
    logic [31:0] f_m_addr, f_m_wdata, f_m_rdata;
    logic [3:0]  f_m_mask;

    int n_total = 0;
    int n_pass  = 0;

    // Controller model
    int   miss_len;
    logic force_busy;
    int   busy_cnt;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    always @(posedge clk or negedge rst_x) begin
        if (!rst_x) busy_cnt <= 0;
        else if (m_rd_en || m_wr_en) busy_cnt <= miss_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    assign m_busy    = force_busy | (busy_cnt != 0);
    assign m_rdata   = mem_model(m_addr);
    assign f_m_busy  = 1'b0;
    assign f_m_rdata = mem_model(f_m_addr);

    mem_port_arbiter #(.ADDR_W(32), .FIXED_PRIO(0), .TIMEOUT(16)) dut (
        .clk(clk), .rst_x(rst_x),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_mask(m_mask), .m_rdata(m_rdata), .m_busy(m_busy), .o_timeout(o_timeout)
    );

    mem_port_arbiter #(.ADDR_W(32), .FIXED_PRIO(1), .TIMEOUT(4096)) dut_fp (
        .clk(clk), .rst_x(rst_x),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(f_i_gnt), .i_rvalid(f_i_rvalid), .i_rdata(f_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .d_gnt(f_d_gnt), .d_rvalid(f_d_rvalid), .d_rdata(f_d_rdata),
        .m_rd_en(f_m_rd_en), .m_wr_en(f_m_wr_en), .m_addr(f_m_addr), .m_wdata(f_m_wdata),
        .m_mask(f_m_mask), .m_rdata(f_m_rdata), .m_busy(f_m_busy), .o_timeout(f_o_timeout)
    );

    // Inputs change just after the rising edge; outputs are sampled on the falling edge
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic apply_reset;
        rst_x = 1'b0;
        next_cycle();
        rst_x = 1'b1;
    endtask

    task automatic test_reset;
        logic [138:0] obs;
        rst_x = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_mask = '0; miss_len = 0; force_busy = 1'b0;
        next_cycle();
        mid();
        obs = {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_rd_en, m_wr_en,
               m_addr, m_wdata, m_mask, o_timeout};
        n_total++;
        if (obs !== '0) $display("FAIL reset_outputs: got %h, expected 0", obs);
        else n_pass++;
        obs = {f_i_gnt, f_i_rvalid, f_i_rdata, f_d_gnt, f_d_rvalid, f_d_rdata, f_m_rd_en,
               f_m_wr_en, f_m_addr, f_m_wdata, f_m_mask, f_o_timeout};
        n_total++;
        if (obs !== '0) $display("FAIL reset_outputs_fp: got %h, expected 0", obs);
        else n_pass++;
        next_cycle();
        rst_x = 1'b1;
    endtask

    task automatic test_i_read_hit;
        int rv_at, strobes, d_rv;
        logic [31:0] rd, addr_at;
        rv_at = -1; strobes = 0; d_rv = 0; rd = '0; addr_at = '0;
        miss_len = 0;
        next_cycle();
        i_req = 1'b1; i_addr = 32'h100;
        mid();
        n_total++;
        if (i_gnt !== 1'b1) $display("FAIL ird_gnt: got %b, expected 1", i_gnt); else n_pass++;
        next_cycle();
        i_req = 1'b0;
        mid();
        n_total++;
        if ({m_rd_en, m_wr_en} !== 2'b10) $display("FAIL ird_strobe: got %b, expected 10", {m_rd_en, m_wr_en});
        else n_pass++;
        n_total++;
        if (m_addr !== 32'h100) $display("FAIL ird_addr: got %h, expected 100", m_addr); else n_pass++;
        n_total++;
        if (m_mask !== 4'hF) $display("FAIL ird_mask: got %h, expected f", m_mask); else n_pass++;
        for (int t = 1; t <= 10; t++) begin
            next_cycle();
            mid();
            if (m_rd_en || m_wr_en) strobes++;
            if (d_rvalid) d_rv++;
            if (i_rvalid && rv_at < 0) begin rv_at = t; rd = i_rdata; addr_at = m_addr; end
        end
        n_total++;
        if (rv_at !== 3) $display("FAIL ird_latency: got %0d, expected 3", rv_at); else n_pass++;
        n_total++;
        if (rd !== mem_model(32'h100)) $display("FAIL ird_data: got %h, expected %h", rd, mem_model(32'h100));
        else n_pass++;
        n_total++;
        if (addr_at !== 32'h100) $display("FAIL ird_addr_hold: got %h, expected 100", addr_at); else n_pass++;
        n_total++;
        if (strobes !== 0 || d_rv !== 0)
            $display("FAIL ird_extra: got strobes=%0d d_rvalid=%0d, expected 0 0", strobes, d_rv);
        else n_pass++;
    endtask

    task automatic test_d_write_miss;
        int rv_at, strobes, rv_cnt;
        logic [31:0] rd;
        rv_at = -1; strobes = 0; rv_cnt = 0; rd = 32'hFFFF_FFFF;
        miss_len = 5;
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hA5A5_0F0F; d_mask = 4'b0011;
        mid();
        n_total++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) $display("FAIL dwr_gnt: got d=%b i=%b, expected d=1 i=0", d_gnt, i_gnt);
        else n_pass++;
        next_cycle();
        d_req = 1'b0; d_we = 1'b0;
        mid();
        n_total++;
        if ({m_rd_en, m_wr_en} !== 2'b01) $display("FAIL dwr_strobe: got %b, expected 01", {m_rd_en, m_wr_en});
        else n_pass++;
        n_total++;
        if ({m_addr, m_wdata, m_mask} !== {32'h200, 32'hA5A5_0F0F, 4'h3})
            $display("FAIL dwr_fields: got %h/%h/%h, expected 200/a5a50f0f/3", m_addr, m_wdata, m_mask);
        else n_pass++;
        for (int t = 1; t <= 14; t++) begin
            next_cycle();
            mid();
            if (m_rd_en || m_wr_en) strobes++;
            if (d_rvalid) begin rv_cnt++; if (rv_at < 0) begin rv_at = t; rd = d_rdata; end end
        end
        n_total++;
        if (rv_at !== 7) $display("FAIL dwr_latency: got %0d, expected 7", rv_at); else n_pass++;
        n_total++;
        if (rd !== 32'h0) $display("FAIL dwr_rdata: got %h, expected 0", rd); else n_pass++;
        n_total++;
        if (strobes !== 0 || rv_cnt !== 1)
            $display("FAIL dwr_pulses: got strobes=%0d rvalid=%0d, expected 0 1", strobes, rv_cnt);
        else n_pass++;
    endtask

    task automatic test_round_robin;
        logic seq [4];
        int ng, both, fp_i, fp_d, found;
        ng = 0; both = 0; fp_i = 0; fp_d = 0; found = 0;
        for (int k = 0; k < 4; k++) seq[k] = 1'bx;
        miss_len = 0;
        apply_reset();
        i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        for (int t = 0; t < 40 && ng < 4; t++) begin
            mid();
            if (i_gnt && d_gnt) both++;
            if (d_gnt) begin seq[ng] = 1'b1; ng++; end
            else if (i_gnt) begin seq[ng] = 1'b0; ng++; end
            if (f_i_gnt) fp_i++;
            if (f_d_gnt) fp_d++;
            next_cycle();
        end
        n_total++;
        if (ng !== 4 || both !== 0) $display("FAIL rr_count: got grants=%0d dual=%0d, expected 4 0", ng, both);
        else n_pass++;
        n_total++;
        if ({seq[0], seq[1], seq[2], seq[3]} !== 4'b1010)
            $display("FAIL rr_order: got %b, expected 1010 (D,I,D,I)", {seq[0], seq[1], seq[2], seq[3]});
        else n_pass++;
        n_total++;
        if (fp_i !== 0 || fp_d !== 4) $display("FAIL fp_d_only: got i=%0d d=%0d, expected 0 4", fp_i, fp_d);
        else n_pass++;
        d_req = 1'b0;
        for (int t = 0; t < 10 && found == 0; t++) begin
            mid();
            if (f_i_gnt) found = 1;
            next_cycle();
        end
        n_total++;
        if (found !== 1) $display("FAIL fp_i_after_drop: got %0d, expected 1", found); else n_pass++;
        i_req = 1'b0;
        repeat (8) next_cycle();
    endtask

    task automatic test_busy_hold;
        int gnts, strobes, rv;
        logic [31:0] rd;
        gnts = 0; strobes = 0; rv = 0; rd = '0;
        miss_len = 0;
        force_busy = 1'b1;
        i_req = 1'b1; i_addr = 32'h500;
        for (int t = 0; t < 6; t++) begin
            mid();
            if (i_gnt || d_gnt) gnts++;
            next_cycle();
        end
        n_total++;
        if (gnts !== 0) $display("FAIL busy_no_gnt: got %0d, expected 0", gnts); else n_pass++;
        force_busy = 1'b0;
        mid();
        n_total++;
        if (i_gnt !== 1'b1) $display("FAIL busy_release_gnt: got %b, expected 1", i_gnt); else n_pass++;
        next_cycle();
        i_req = 1'b0;
        for (int t = 0; t < 8; t++) begin
            mid();
            if (m_rd_en) strobes++;
            if (i_rvalid) begin rv++; rd = i_rdata; end
            next_cycle();
        end
        n_total++;
        if (strobes !== 1 || rv !== 1) $display("FAIL busy_one_txn: got strobes=%0d rvalid=%0d, expected 1 1", strobes, rv);
        else n_pass++;
        n_total++;
        if (rd !== mem_model(32'h500)) $display("FAIL busy_data: got %h, expected %h", rd, mem_model(32'h500));
        else n_pass++;
    endtask

    task automatic test_timeout;
        int first_to, rv;
        logic [31:0] rd;
        first_to = -1; rv = 0; rd = '0;
        miss_len = 0;
        next_cycle();
        i_req = 1'b1; i_addr = 32'h600;
        mid();
        n_total++;
        if (i_gnt !== 1'b1) $display("FAIL to_gnt: got %b, expected 1", i_gnt); else n_pass++;
        next_cycle();
        i_req = 1'b0; force_busy = 1'b1;
        mid();
        for (int w = 1; w <= 30; w++) begin
            next_cycle();
            mid();
            if (o_timeout && first_to < 0) first_to = w;
            if (i_rvalid || d_rvalid) rv++;
        end
        n_total++;
        if (first_to !== 17) $display("FAIL to_set_cycle: got %0d, expected 17", first_to); else n_pass++;
        n_total++;
        if (rv !== 0) $display("FAIL to_no_rvalid: got %0d, expected 0", rv); else n_pass++;
        next_cycle();
        force_busy = 1'b0;
        for (int t = 0; t < 5; t++) begin
            mid();
            if (i_rvalid) begin rv++; rd = i_rdata; end
            next_cycle();
        end
        n_total++;
        if (rv !== 1 || rd !== mem_model(32'h600))
            $display("FAIL to_release: got rvalid=%0d data=%h, expected 1 %h", rv, rd, mem_model(32'h600));
        else n_pass++;
        n_total++;
        if (o_timeout !== 1'b1) $display("FAIL to_sticky: got %b, expected 1", o_timeout); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [138:0] obs;
        int rv, rv_at;
        logic [31:0] rd;
        rv = 0; rv_at = -1; rd = '0;
        miss_len = 8;
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
        mid();
        n_total++;
        if (d_gnt !== 1'b1) $display("FAIL rmid_gnt: got %b, expected 1", d_gnt); else n_pass++;
        next_cycle();
        d_req = 1'b0;
        next_cycle();
        next_cycle();
        rst_x = 1'b0;
        #1;
        obs = {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_rd_en, m_wr_en,
               m_addr, m_wdata, m_mask, o_timeout};
        n_total++;
        if (obs !== '0) $display("FAIL rmid_outputs: got %h, expected 0", obs); else n_pass++;
        next_cycle();
        rst_x = 1'b1;
        for (int t = 0; t < 10; t++) begin
            mid();
            if (i_rvalid || d_rvalid) rv++;
            next_cycle();
        end
        n_total++;
        if (rv !== 0) $display("FAIL rmid_no_rvalid: got %0d, expected 0", rv); else n_pass++;
        miss_len = 0;
        i_req = 1'b1; i_addr = 32'h800;
        mid();
        n_total++;
        if (i_gnt !== 1'b1) $display("FAIL rmid_next_gnt: got %b, expected 1", i_gnt); else n_pass++;
        next_cycle();
        i_req = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            next_cycle();
            mid();
            if (i_rvalid && rv_at < 0) begin rv_at = t; rd = i_rdata; end
        end
        n_total++;
        if (rv_at !== 3 || rd !== mem_model(32'h800))
            $display("FAIL rmid_next_txn: got at=%0d data=%h, expected 3 %h", rv_at, rd, mem_model(32'h800));
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running, expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_i_read_hit();
        test_d_write_miss();
        test_round_robin();
        test_busy_hold();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
